// File: rtl/lifo_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto one lifo_top, tracking occupancy and returning tagged results.
// Define LIFO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module lifo_req_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int DATA_WIDTH   = 4,
   parameter int NUM_ENTRIES  = 4,
   parameter int OPCODE_WIDTH = 2,
   parameter int ID_W         = $clog2(NUM_REQ),
   parameter int CNT_W        = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [2*NUM_REQ-1:0]             req_op,
   input  logic [DATA_WIDTH*NUM_REQ-1:0]    req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] lifo_vector,
   input  logic [DATA_WIDTH-1:0]            lifo_rdata,
   output logic                             rsp_valid,
   output logic [ID_W-1:0]                  rsp_id,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             rsp_err,
   output logic [CNT_W-1:0]                 count,
   output logic                             full,
   output logic                             empty
);

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PUSH = 2'b10;

   logic [NUM_REQ-1:0]    eligible;
   logic                  hit;
   logic                  grant;
   logic [ID_W-1:0]       win;
   logic [1:0]            sel_op;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  push_ok;
   logic                  pop_ok;

   // Response pipeline: index 0 is the cycle after grant, index 1 drives the outputs.
   logic [1:0]            vld_pipe;
   logic [1:0][ID_W-1:0]  id_pipe;
   logic [1:0]            pop_pipe;
   logic [1:0]            err_pipe;

   // Op 00 is "no request" even with valid high, so it never competes.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = req_valid[i] && (req_op[2*i +: 2] != OP_NOP);
   end

`ifdef LIFO_ARB_FIXED_PRIO_EN
   always_comb begin
      hit = 1'b0;
      win = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            hit = 1'b1;
            win = ID_W'(k);
         end
      end
   end
`else
   logic [ID_W-1:0] rr_ptr;
   int              idx;

   always_comb begin
      hit = 1'b0;
      win = '0;
      idx = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + 1 + k) % NUM_REQ;
         if (!hit && eligible[idx]) begin
            hit = 1'b1;
            win = ID_W'(idx);
         end
      end
   end
`endif

   assign grant     = hit && !reset;
   assign req_ready = grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win) : '0;

   assign sel_op   = req_op[2*int'(win) +: 2];
   assign sel_data = req_data[DATA_WIDTH*int'(win) +: DATA_WIDTH];
   assign push_ok  = (sel_op == OP_PUSH) && (count < CNT_W'(NUM_ENTRIES));
   assign pop_ok   = (sel_op == OP_POP) && (count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         lifo_vector <= '0;
         count       <= '0;
         vld_pipe    <= '0;
         id_pipe     <= '0;
         pop_pipe    <= '0;
         err_pipe    <= '0;
`ifndef LIFO_ARB_FIXED_PRIO_EN
         rr_ptr      <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         vld_pipe <= {vld_pipe[0], grant};
         id_pipe  <= {id_pipe[0], win};
         pop_pipe <= {pop_pipe[0], grant && pop_ok};
         err_pipe <= {err_pipe[0], grant && !(push_ok || pop_ok)};

         // A command lives on the vector for exactly one cycle.
         if (grant && push_ok)
            lifo_vector <= {OP_PUSH, sel_data};
         else if (grant && pop_ok)
            lifo_vector <= {OP_POP, {DATA_WIDTH{1'b0}}};
         else
            lifo_vector <= '0;

         if (grant && push_ok)
            count <= count + 1'b1;
         else if (grant && pop_ok)
            count <= count - 1'b1;
`ifndef LIFO_ARB_FIXED_PRIO_EN
         if (grant)
            rr_ptr <= win;
`endif
      end
   end

   assign rsp_valid = vld_pipe[1];
   assign rsp_id    = id_pipe[1];
   assign rsp_err   = err_pipe[1];
   // lifo_top's data_out carries the popped value in the response cycle.
   assign rsp_data  = (vld_pipe[1] && pop_pipe[1]) ? lifo_rdata : '0;

   assign full  = (count == CNT_W'(NUM_ENTRIES));
   assign empty = (count == '0);

endmodule

// File: tb/tb_lifo_req_arbiter.sv
// Randomized and directed bench for lifo_req_arbiter, with a queue-based reference model
// and a small behavioural lifo_top stub driving lifo_rdata.
module tb_lifo_req_arbiter;
   localparam int N  = 4;
   localparam int DW = 4;
   localparam int NE = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req_valid = '0;
   logic [2*N-1:0]  req_op = '0;
   logic [DW*N-1:0] req_data = '0;
   logic [N-1:0]    req_ready;
   logic [5:0]      lifo_vector;
   logic [DW-1:0]   lifo_rdata;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            rsp_err;
   logic [2:0]      count;
   logic            full;
   logic            empty;

   int n_tests = 0;
   int n_fail  = 0;

   lifo_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .lifo_vector(lifo_vector), .lifo_rdata(lifo_rdata),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // lifo_top stand-in: executes the command vector, registers popped data on data_out.
   logic [DW-1:0] lmem [0:7];
   int            lsp = 0;
   always @(posedge clk) begin
      if (reset) begin
         lsp        <= 0;
         lifo_rdata <= '0;
      end else if (lifo_vector[5:4] == 2'b10) begin
         lmem[lsp] <= lifo_vector[3:0];
         lsp       <= lsp + 1;
      end else if (lifo_vector[5:4] == 2'b01 && lsp > 0) begin
         lifo_rdata <= lmem[lsp-1];
         lsp        <= lsp - 1;
      end
   end

   // Reference model state
   typedef struct {int due; int id; bit err; logic [DW-1:0] data;} rsp_t;
   rsp_t          rq[$];
   logic [DW-1:0] stk[$];
   int            last_win = N - 1;
   int            cyc = 0;
   logic [5:0]    exp_vec = '0;
   logic [N-1:0]  g_exp = '0;

   task automatic set_req(input int i, input bit v, input logic [1:0] op, input logic [DW-1:0] d);
      req_valid[i]        = v;
      req_op[2*i +: 2]    = op;
      req_data[DW*i +: DW] = d;
   endtask

   // Advance one cycle: compare DUT against the model, then update the model.
   task automatic step();
      bit            hit, ev, eerr, legal;
      int            win, idx, eid, op;
      logic [DW-1:0] edata, d;
      logic [5:0]    nvec;
      #1;
      hit = 0; win = 0;
      if (!reset) begin
         for (int k = 0; k < N; k++) begin
`ifdef LIFO_ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = (last_win + 1 + k) % N;
`endif
            if (!hit && req_valid[idx] && req_op[2*idx +: 2] != 2'b00) begin
               hit = 1; win = idx;
            end
         end
      end
      g_exp = hit ? (N'(1) << win) : '0;
      n_tests++;
      if (req_ready !== g_exp) begin
         n_fail++; $display("FAIL req_ready cyc=%0d got %b exp %b", cyc, req_ready, g_exp);
      end
      ev = 0; eid = 0; eerr = 0; edata = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         ev = 1; eid = rq[0].id; eerr = rq[0].err; edata = rq[0].data;
         void'(rq.pop_front());
      end
      n_tests++;
      if (rsp_valid !== ev) begin
         n_fail++; $display("FAIL rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, ev);
      end else if (ev && (rsp_id !== 2'(eid) || rsp_err !== eerr)) begin
         n_fail++; $display("FAIL rsp_id/err cyc=%0d got %0d/%b exp %0d/%b", cyc, rsp_id, rsp_err, eid, eerr);
      end
      n_tests++;
      if (rsp_data !== edata) begin
         n_fail++; $display("FAIL rsp_data cyc=%0d got %h exp %h", cyc, rsp_data, edata);
      end
      n_tests++;
      if (lifo_vector !== exp_vec) begin
         n_fail++; $display("FAIL lifo_vector cyc=%0d got %b exp %b", cyc, lifo_vector, exp_vec);
      end
      n_tests++;
      if (count !== 3'(stk.size()) || full !== (stk.size() == NE) || empty !== (stk.size() == 0)) begin
         n_fail++; $display("FAIL occupancy cyc=%0d got %0d f%b e%b exp %0d", cyc, count, full, empty, stk.size());
      end
      nvec = '0;
      if (hit) begin
         op = int'(req_op[2*win +: 2]);
         d  = req_data[DW*win +: DW];
         legal = 0; edata = '0;
         if (op == 2 && stk.size() < NE) begin
            legal = 1; stk.push_back(d); nvec = {2'b10, d};
         end else if (op == 1 && stk.size() > 0) begin
            legal = 1; edata = stk.pop_back(); nvec = 6'b01_0000;
         end
         rq.push_back('{cyc + 2, win, !legal, edata});
         last_win = win;
      end
      @(posedge clk);
      if (reset) begin
         rq.delete(); stk.delete(); last_win = N - 1; nvec = '0;
      end
      exp_vec = nvec;
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1; req_valid = '0;
      step(); step();
      reset = 0;
   endtask

   task automatic test_reset();
      #1;
      n_tests++;
      if (req_ready !== '0 || lifo_vector !== '0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl got rdy %b vec %b rv %b exp 0 0 0", req_ready, lifo_vector, rsp_valid);
      end
      n_tests++;
      if (rsp_id !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_rsp got id %0d d %h e %b exp 0 0 0", rsp_id, rsp_data, rsp_err);
      end
      n_tests++;
      if (count !== '0 || full !== 1'b0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL reset_occ got c %0d f %b e %b exp 0 0 1", count, full, empty);
      end
      reset = 0;
      step();
   endtask

   task automatic test_single_push();
      set_req(0, 1, 2'b10, 4'h5);
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL push1_ready got %b exp 0001", req_ready);
      end
      step();
      set_req(0, 0, 2'b00, 4'h0);
      n_tests++;
      if (lifo_vector !== 6'b10_0101) begin
         n_fail++; $display("FAIL push1_vec got %b exp 100101", lifo_vector);
      end
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || count !== 3'd1) begin
         n_fail++; $display("FAIL push1_rsp got v%b id%0d e%b c%0d exp v1 id0 e0 c1", rsp_valid, rsp_id, rsp_err, count);
      end
   endtask

   task automatic test_fill();
      do_reset();
      for (int d = 1; d <= 5; d++) begin
         set_req(1, 1, 2'b10, 4'(d));
         step();
         if (d == 4) begin
            n_tests++;
            if (full !== 1'b1) begin
               n_fail++; $display("FAIL fill_full got %b exp 1", full);
            end
         end
      end
      set_req(1, 0, 2'b00, 4'h0);
      n_tests++;
      if (lifo_vector !== 6'b0) begin
         n_fail++; $display("FAIL fill_overflow_vec got %b exp 000000", lifo_vector);
      end
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_id !== 2'd1 || count !== 3'd4) begin
         n_fail++; $display("FAIL fill_overflow_rsp got v%b e%b id%0d c%0d exp v1 e1 id1 c4", rsp_valid, rsp_err, rsp_id, count);
      end
   endtask

   task automatic test_drain();
      logic [DW-1:0] e;
      for (int i = 0; i < 6; i++) begin
         set_req(2, i < 4, 2'b01, 4'h0);
         step();
         if (i >= 1 && i <= 4) begin
            e = 4'(5 - i);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== e) begin
               n_fail++; $display("FAIL drain_data i=%0d got v%b %h exp v1 %h", i, rsp_valid, rsp_data, e);
            end
         end
      end
      n_tests++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL drain_empty got %b exp 1", empty);
      end
      set_req(2, 1, 2'b01, 4'h0);
      step();
      set_req(2, 0, 2'b00, 4'h0);
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
         n_fail++; $display("FAIL drain_underflow got v%b e%b d%h exp v1 e1 d0", rsp_valid, rsp_err, rsp_data);
      end
   endtask

   task automatic test_rr();
      logic [N-1:0] e;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         for (int r = 0; r < N; r++) set_req(r, 1, 2'b10, 4'($urandom_range(0, 15)));
         #1;
`ifdef LIFO_ARB_FIXED_PRIO_EN
         e = 4'b0001;
`else
         e = 4'b0001 << (i % N);
`endif
         n_tests++;
         if (req_ready !== e) begin
            n_fail++; $display("FAIL rr_order i=%0d got %b exp %b", i, req_ready, e);
         end
         step();
      end
      req_valid = '0;
      step(); step();
      n_tests++;
      if (count !== 3'd4) begin
         n_fail++; $display("FAIL rr_count got %0d exp 4", count);
      end
   endtask

   task automatic test_invalid();
      do_reset();
      set_req(0, 1, 2'b10, 4'hA);
      step();
      set_req(0, 0, 2'b00, 4'h0);
      set_req(3, 1, 2'b11, 4'h7);
      step();
      set_req(3, 0, 2'b00, 4'h0);
      step();
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_err !== 1'b1 || count !== 3'd1) begin
         n_fail++; $display("FAIL invalid_op got v%b id%0d e%b c%0d exp v1 id3 e1 c1", rsp_valid, rsp_id, rsp_err, count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      set_req(0, 1, 2'b10, 4'h9);
      step();
      set_req(0, 0, 2'b00, 4'h0);
      step();
      set_req(0, 1, 2'b01, 4'h0);
      step();
      set_req(0, 0, 2'b00, 4'h0);
      n_tests++;
      if (lifo_vector !== 6'b01_0000) begin
         n_fail++; $display("FAIL midrst_popvec got %b exp 010000", lifo_vector);
      end
      reset = 1;
      step();
      reset = 0;
      n_tests++;
      if (rsp_valid !== 1'b0 || count !== 3'd0 || lifo_vector !== 6'b0) begin
         n_fail++; $display("FAIL midrst_after got v%b c%0d vec %b exp v0 c0 000000", rsp_valid, count, lifo_vector);
      end
      step();
   endtask

   task automatic test_random();
      int r;
      logic [1:0] op;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || g_exp[i] || req_op[2*i +: 2] == 2'b00) begin
               if ($urandom_range(0, 2) != 0) begin
                  r  = $urandom_range(0, 15);
                  op = (r < 7) ? 2'b10 : (r < 13) ? 2'b01 : (r < 15) ? 2'b11 : 2'b00;
                  set_req(i, 1, op, 4'($urandom_range(0, 15)));
               end else begin
                  set_req(i, 0, 2'b00, 4'h0);
               end
            end
         end
         step();
      end
      req_valid = '0;
      step(); step(); step();
   endtask

   initial begin
      reset = 1;
      repeat (2) @(negedge clk);
      test_reset();
      test_single_push();
      test_fill();
      test_drain();
      test_rr();
      test_invalid();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
